// File: rtl/mpu_mul_seq_if.sv
// mpu_mul_seq_if: operand/result bundle for the sequential matrix-multiply unit.
//
// Signals (master = requester, slave = mpu_mul_seq):
//   start      request, sampled by the unit only while idle
//   size       active dimension n, sampled with start
//   saturate   1 = clamp each element to 2^WIDTH-1, 0 = keep low WIDTH bits
//   matrix_a   left operand, element (i,j) at [(i*DIM+j)*WIDTH +: WIDTH]
//   matrix_b   right operand, same packing
//   result     registered product, same packing
//   busy       high while the unit clears and accumulates
//   done       one-cycle completion pulse
//   overflow   some exact element sum exceeded 2^WIDTH-1 in the last operation
//   state_dbg  current controller state (debug visibility)
//
// Handshake: a request is accepted on the rising edge where start=1 and the
// unit is idle (busy=0, done=0); operands, size and saturate are captured on
// that edge only. start at any other time is dropped, not queued. done pulses
// for exactly one cycle when the product is final; result and overflow then
// hold until the next accepted request clears them.
interface mpu_mul_seq_if #(
  parameter int WIDTH = 8,
  parameter int DIM   = 5
);
  logic                       start;
  logic [7:0]                 size;
  logic                       saturate;
  logic [DIM*DIM*WIDTH-1:0]   matrix_a;
  logic [DIM*DIM*WIDTH-1:0]   matrix_b;
  logic [DIM*DIM*WIDTH-1:0]   result;
  logic                       busy;
  logic                       done;
  logic                       overflow;
  logic [1:0]                 state_dbg;

  modport master (
    output start, size, saturate, matrix_a, matrix_b,
    input  result, busy, done, overflow, state_dbg
  );

  modport slave (
    input  start, size, saturate, matrix_a, matrix_b,
    output result, busy, done, overflow, state_dbg
  );
endinterface

// File: rtl/mpu_mul_seq.sv
// mpu_mul_seq: sequential unsigned square matrix multiply, one MAC per cycle.
//
// Ports:
//   clock  rising-edge clock
//   reset  synchronous active-high reset; aborts any running operation
//   bus    mpu_mul_seq_if.slave (start/size/saturate/operands in,
//          result/busy/done/overflow/state_dbg out)
//
// Only the top-left n x n block is computed; n is size clamped to 1..DIM.
// Sequence: IDLE -> CLEAR (zero result) -> MAC (n^3 cycles, k innermost)
// -> DONE (one-cycle pulse) -> IDLE.
module mpu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int DIM   = 5
) (
  input  logic         clock,
  input  logic         reset,
  mpu_mul_seq_if.slave bus
);
  localparam int P    = DIM * DIM * WIDTH;
  // Wide enough for up to 8 products of two WIDTH-bit values.
  localparam int ACCW = 2 * WIDTH + 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_MAC   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [P-1:0]      a_q, b_q, result_q;
  logic              sat_q, ovf_q;
  logic [3:0]        n_q, i_q, j_q, k_q;
  logic [ACCW-1:0]   acc_q, acc_next;
  logic [WIDTH-1:0]  a_el, b_el, res_el;
  logic [2*WIDTH-1:0] prod;
  logic              last_k, last_j, last_i, elem_ovf;
  logic [3:0]        n_eff;
  int                a_idx, b_idx, r_idx;

  // Effective dimension: 0 means 1, anything above DIM means DIM.
  always_comb begin
    n_eff = bus.size[3:0];
    if (bus.size == 8'd0) begin
      n_eff = 4'd1;
    end else if (bus.size > 8'(DIM)) begin
      n_eff = 4'(DIM);
    end
  end

  // MAC datapath for the current (i, j, k).
  always_comb begin
    a_idx    = (int'(i_q) * DIM + int'(k_q)) * WIDTH;
    b_idx    = (int'(k_q) * DIM + int'(j_q)) * WIDTH;
    r_idx    = (int'(i_q) * DIM + int'(j_q)) * WIDTH;
    a_el     = a_q[a_idx +: WIDTH];
    b_el     = b_q[b_idx +: WIDTH];
    prod     = a_el * b_el;
    acc_next = acc_q + {{(ACCW-2*WIDTH){1'b0}}, prod};
    elem_ovf = |acc_next[ACCW-1:WIDTH];
    res_el   = (sat_q && elem_ovf) ? {WIDTH{1'b1}} : acc_next[WIDTH-1:0];
    last_k   = (k_q == n_q - 4'd1);
    last_j   = (j_q == n_q - 4'd1);
    last_i   = (i_q == n_q - 4'd1);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_MAC;
      S_MAC:   if (last_k && last_j && last_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      n_q      <= 4'd1;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q   <= bus.matrix_a;
            b_q   <= bus.matrix_b;
            sat_q <= bus.saturate;
            n_q   <= n_eff;
          end
        end
        S_CLEAR: begin
          result_q <= '0;
          ovf_q    <= 1'b0;
          i_q      <= '0;
          j_q      <= '0;
          k_q      <= '0;
          acc_q    <= '0;
        end
        S_MAC: begin
          if (last_k) begin
            result_q[r_idx +: WIDTH] <= res_el;
            ovf_q <= ovf_q | elem_ovf;
            acc_q <= '0;
            k_q   <= '0;
            if (last_j) begin
              j_q <= '0;
              i_q <= i_q + 4'd1;
            end else begin
              j_q <= j_q + 4'd1;
            end
          end else begin
            acc_q <= acc_next;
            k_q   <= k_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.busy      = (state_q == S_CLEAR) || (state_q == S_MAC);
  assign bus.done      = (state_q == S_DONE);
  assign bus.overflow  = ovf_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_mpu_mul_seq.sv
module tb_mpu_mul_seq;
  localparam int WIDTH = 8;
  localparam int DIM   = 5;
  localparam int P     = DIM * DIM * WIDTH;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  mpu_mul_seq_if #(.WIDTH(WIDTH), .DIM(DIM)) bus ();

  mpu_mul_seq #(.WIDTH(WIDTH), .DIM(DIM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [P-1:0] obs, input logic [P-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int eff_n(input int size);
    if (size == 0) return 1;
    if (size > DIM) return DIM;
    return size;
  endfunction

  function automatic int get_el(input logic [P-1:0] m, input int i, input int j);
    return int'(m[(i*DIM+j)*WIDTH +: WIDTH]);
  endfunction

  task automatic set_el(inout logic [P-1:0] m, input int i, input int j, input int v);
    m[(i*DIM+j)*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic model(input logic [P-1:0] a, input logic [P-1:0] b, input int n,
                       input bit sat, output logic [P-1:0] r, output bit ovf);
    longint s;
    r   = '0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += longint'(get_el(a, i, k)) * longint'(get_el(b, k, j));
        if (s > MAXV) ovf = 1'b1;
        if (s > MAXV && sat) set_el(r, i, j, MAXV);
        else                 set_el(r, i, j, int'(s % (MAXV + 1)));
      end
    end
  endtask

  function automatic logic [P-1:0] rand_mat(input int maxv);
    logic [P-1:0] m;
    for (int e = 0; e < DIM*DIM; e++) m[e*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, maxv));
    return m;
  endfunction

  // ---------------- driver ----------------
  // poke_mac > 0: pulse start with other operands at that cycle of the run.
  // poke_done: pulse start again while done is high.
  task automatic run_op(input string tag, input logic [P-1:0] a, input logic [P-1:0] b,
                        input int size, input bit sat, input int poke_mac, input bit poke_done);
    logic [P-1:0] exp_r;
    bit           exp_ovf;
    int           n, cyc, busy_cnt;
    n = eff_n(size);
    model(a, b, n, sat, exp_r, exp_ovf);
    bus.matrix_a = a;
    bus.matrix_b = b;
    bus.size     = 8'(size);
    bus.saturate = sat;
    bus.start    = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    while (!bus.done && cyc < 2000) begin
      if (bus.busy) busy_cnt++;
      if (poke_mac > 0 && cyc == poke_mac) begin
        bus.start    = 1'b1;
        bus.matrix_a = rand_mat(MAXV);
        bus.matrix_b = rand_mat(MAXV);
        bus.size     = 8'd2;
        bus.saturate = ~sat;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, "_latency"}, P'(cyc), P'(n*n*n + 2));
    chk({tag, "_busy_cycles"}, P'(busy_cnt), P'(n*n*n + 1));
    chk({tag, "_result"}, bus.result, exp_r);
    chk({tag, "_overflow"}, P'(bus.overflow), P'(exp_ovf));
    if (poke_done) begin
      bus.start    = 1'b1;
      bus.matrix_a = rand_mat(MAXV);
      bus.matrix_b = rand_mat(MAXV);
      bus.size     = 8'd3;
      @(posedge clock); #1;
      bus.start = 1'b0;
      chk({tag, "_idle_busy"}, P'(bus.busy), P'(0));
      busy_cnt = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clock); #1;
        if (bus.busy || bus.done) busy_cnt++;
      end
      chk({tag, "_stays_idle"}, P'(busy_cnt), P'(0));
      chk({tag, "_result_held"}, bus.result, exp_r);
    end else begin
      @(posedge clock); #1;
      chk({tag, "_done_pulse"}, P'(bus.done), P'(0));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [P-1:0] a, b;
    errors = 0;
    checks = 0;
    bus.start    = 1'b0;
    bus.size     = 8'd0;
    bus.saturate = 1'b0;
    bus.matrix_a = '0;
    bus.matrix_b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    chk("reset_result", bus.result, '0);
    chk("reset_busy", P'(bus.busy), P'(0));
    chk("reset_done", P'(bus.done), P'(0));
    chk("reset_overflow", P'(bus.overflow), P'(0));

    // Identity times B gives B.
    a = '0;
    b = '0;
    for (int i = 0; i < DIM; i++) begin
      set_el(a, i, i, 1);
      for (int j = 0; j < DIM; j++) set_el(b, i, j, 5*i + j);
    end
    run_op("identity", a, b, 5, 1'b0, 0, 1'b0);
    chk("identity_is_b", bus.result, b);

    // Size masking: 0xFF outside the 2x2 block must not leak in.
    a = '1;
    b = '1;
    set_el(a, 0, 0, 1); set_el(a, 0, 1, 2); set_el(a, 1, 0, 3); set_el(a, 1, 1, 4);
    set_el(b, 0, 0, 5); set_el(b, 0, 1, 6); set_el(b, 1, 0, 7); set_el(b, 1, 1, 8);
    run_op("mask", a, b, 2, 1'b0, 0, 1'b0);
    a = '0;
    set_el(a, 0, 0, 19); set_el(a, 0, 1, 22); set_el(a, 1, 0, 43); set_el(a, 1, 1, 50);
    chk("mask_literal", bus.result, a);

    // Wrap vs saturate: each sum 768.
    a = '0;
    for (int e = 0; e < DIM*DIM; e++) a[e*WIDTH +: WIDTH] = 8'h10;
    run_op("wrap", a, a, 3, 1'b0, 0, 1'b0);
    run_op("sat", a, a, 3, 1'b1, 0, 1'b0);
    b = '0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) set_el(b, i, j, 255);
    chk("sat_literal", bus.result, b);

    // Size clamp.
    run_op("size0", rand_mat(MAXV), rand_mat(MAXV), 0, 1'b0, 0, 1'b0);
    run_op("size9", rand_mat(15), rand_mat(15), 9, 1'b0, 0, 1'b0);

    // Start during MAC and during DONE is ignored.
    run_op("ignore", rand_mat(MAXV), rand_mat(MAXV), 5, 1'b1, 30, 1'b1);

    // Reset at MAC cycle 40, then a clean run.
    bus.matrix_a = rand_mat(MAXV);
    bus.matrix_b = rand_mat(MAXV);
    bus.size     = 8'd5;
    bus.saturate = 1'b0;
    bus.start    = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (41) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst_busy", P'(bus.busy), P'(0));
    chk("midrst_done", P'(bus.done), P'(0));
    chk("midrst_result", bus.result, '0);
    chk("midrst_overflow", P'(bus.overflow), P'(0));
    run_op("after_rst", rand_mat(MAXV), rand_mat(MAXV), 4, 1'b0, 0, 1'b0);

    // Randomised operations, mix of small (no overflow) and full-range values.
    for (int t = 0; t < 8; t++) begin
      int sz;
      int mv;
      sz = $urandom_range(0, 10);
      mv = (t % 2 == 0) ? 15 : MAXV;
      run_op($sformatf("rand%0d", t), rand_mat(mv), rand_mat(mv), sz,
             1'($urandom_range(0, 1)), 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mpu_mul_seq.md
# mpu_mul_seq

Parametrised, sequential matrix-multiply unit for the MPU datapath, the next generation of the fixed 5×5 combinational multiplier. It multiplies two square unsigned matrices of up to `DIM`×`DIM` elements, each `WIDTH` bits wide. Only the top-left `size`×`size` sub-matrix is used. The unit runs one multiply-accumulate per cycle behind a start/done handshake, and either wraps or saturates each result element.

## Interface
- `WIDTH`, 8: element width in bits (unsigned).
- `DIM`, 5: maximum matrix dimension; supported range 2..8.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: operation request, sampled only in IDLE.
- `size`  in  8: active dimension n, sampled with `start`.
- `saturate`  in  1: 1 = clamp results to 2^WIDTH−1; 0 = keep the low `WIDTH` bits. Sampled with `start`.
- `matrix_a`  in  DIM·DIM·WIDTH: left operand. Element (i,j) is at bits [(i·DIM+j)·WIDTH +: WIDTH]. Sampled with `start`.
- `matrix_b`  in  DIM·DIM·WIDTH: right operand, same packing.
- `result`  out  DIM·DIM·WIDTH: product, same packing, registered.
- `busy`  out  1: high in CLEAR and MAC.
- `done`  out  1: one-cycle pulse in DONE.
- `overflow`  out  1: set if any element's exact sum exceeded 2^WIDTH−1 in the last operation; valid from `done` until the next accepted `start`.

## Operation
- States: IDLE → CLEAR → MAC → DONE → IDLE.
- **IDLE.** On `start`=1, latch `matrix_a`, `matrix_b`, `saturate` and the effective size n into internal registers.
  - n = 1 if `size`=0; n = DIM if `size`>DIM; otherwise n = `size`.
  - Later input changes have no effect on the running operation.
- **CLEAR.** One cycle:
  - `result` ← all zero.
  - `overflow` ← 0.
  - Indices i, j, k ← 0; accumulator ← 0.
- **MAC.** One cycle per (i, j, k), with k innermost, then j, then i, all ranging over 0..n−1:
  - acc_next = acc + a[i][k]·b[k][j], computed at full width. The accumulator is 2·WIDTH+3 bits wide and cannot overflow.
  - When k = n−1:
    - If `saturate`=0, result(i,j) ← acc_next[WIDTH−1:0].
    - If `saturate`=1, result(i,j) ← min(acc_next, 2^WIDTH−1).
    - `overflow` |= (acc_next > 2^WIDTH−1).
    - acc ← 0; k ← 0; (i,j) advance.
  - After element (n−1, n−1) is written, go to DONE.
- **Outside the active area.** Operand elements with a row or column ≥ n are never read. Result elements with a row or column ≥ n stay 0 from CLEAR.
- **DONE.** `done`=1 for one cycle, `busy`=0, then go to IDLE.
  - `result` and `overflow` hold until the CLEAR of the next operation.
- **`start` outside IDLE** (CLEAR, MAC or DONE) is ignored. It is not queued.
- **Reset** at any time, including mid-operation:
  - Next state IDLE; the operation is aborted.
  - `result`=0, `busy`=0, `done`=0, `overflow`=0, internal indices and accumulator = 0.

## Timing
- Edge E0 samples `start`=1 in IDLE.
- Edge E1: CLEAR completes and `result` reads zero.
- Edges E2..E(n³+1): MAC steps.
- `done` is high in the cycle after edge E(n³+2) − 1, i.e. `done` asserts n³+2 cycles after E0.
  - n=5: 127 cycles. n=1: 3 cycles. n=8: 514 cycles.
- Element (i,j) becomes visible after edge E(2 + (i·n+j)·n + n−1) and does not change afterwards.
- Earliest next accepted `start`: the edge after `done`. Back-to-back operations therefore have a period of n³+3 cycles.

## Test plan
- **Identity.** DIM=5, n=5, A=I, B[i][j]=5i+j, `saturate`=0 → `result`=B. `done` 127 cycles after start; `busy` high for exactly 126 cycles.
- **Size masking.** n=2, A and B filled with 0xFF outside the 2×2 area, inner area A=[[1,2],[3,4]], B=[[5,6],[7,8]] → result [[19,22],[43,50]], every other element 0, `overflow`=0, `done` after 10 cycles.
- **Wrap vs saturate.** n=3, A=B all 0x10, so each exact sum is 768.
  - `saturate`=0 → every active element is 0x00, `overflow`=1.
  - `saturate`=1 → every active element is 0xFF, `overflow`=1.
- **Size clamp.** `size`=0 → 1×1 product a00·b00, `done` after 3 cycles. `size`=9 → full 5×5 product, `done` after 127 cycles.
- **Ignored start.** Pulse `start` with different operands during MAC and again during DONE → the first result is unchanged, no second operation runs, and the unit stays IDLE after `done`.
- **Reset mid-operation.** Assert `reset` for one cycle at MAC cycle 40 → next cycle `busy`=0, `done`=0, `result`=0, `overflow`=0. A following `start` completes normally with the correct result.
